axi_config_rdwr: RTL and testbench

AXI4 slave to simple register-bus bridge. It accepts full AXI4 read and write bursts and splits each beat into single-cycle `rd`/`wr` strobes with an address and data, for driving a configuration register file. Independent read and write engines run concurrently; any read/write arbitration is done by the parent.

---
 rtl/axi_config_rdwr.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_axi_config_rdwr.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_config_rdwr.sv
// ============================================================================
// axi_config_rdwr
//
// AXI4 slave that turns read and write bursts into single-beat strobes on a
// simple configuration register bus. The read and write engines are
// independent and may strobe in the same cycle; the parent arbitrates.
//
// Ports
//   clk, rst             : clock (rising edge), asynchronous active-low reset
//   s_axi_aw*            : write address channel (lock/cache/prot/qos/region/
//                          user are accepted and ignored)
//   s_axi_w*             : write data channel (wlast/wuser ignored; the beat
//                          count from awlen ends the burst)
//   s_axi_b*             : write response channel (always OKAY)
//   s_axi_ar*            : read address channel (sideband ignored)
//   s_axi_r*             : read data channel (always OKAY)
//   rd, raddr            : one-cycle read strobe and its address
//   rdata, rvalid        : read data returned by the register bus
//   wr, waddr, wdata,
//   wstrb                : one-cycle write strobe with address, data, strobes
// ============================================================================
module axi_config_rdwr #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH     = 8,
    parameter int AWUSER_WIDTH = 1,
    parameter int WUSER_WIDTH  = 1,
    parameter int BUSER_WIDTH  = 1,
    parameter int ARUSER_WIDTH = 1,
    parameter int RUSER_WIDTH  = 1,
    parameter int REG_DATA     = 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic [ID_WIDTH-1:0]     s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_awlock,
    input  logic [3:0]              s_axi_awcache,
    input  logic [2:0]              s_axi_awprot,
    input  logic [3:0]              s_axi_awqos,
    input  logic [3:0]              s_axi_awregion,
    input  logic [AWUSER_WIDTH-1:0] s_axi_awuser,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,

    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
    input  logic                    s_axi_wlast,
    input  logic [WUSER_WIDTH-1:0]  s_axi_wuser,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,

    output logic [ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]              s_axi_bresp,
    output logic [BUSER_WIDTH-1:0]  s_axi_buser,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,

    input  logic [ID_WIDTH-1:0]     s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    input  logic                    s_axi_arlock,
    input  logic [3:0]              s_axi_arcache,
    input  logic [2:0]              s_axi_arprot,
    input  logic [3:0]              s_axi_arqos,
    input  logic [3:0]              s_axi_arregion,
    input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,

    output logic [ID_WIDTH-1:0]     s_axi_rid,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast,
    output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,

    output logic                    rd,
    output logic [ADDR_WIDTH-1:0]   raddr,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    rvalid,

    output logic                    wr,
    output logic [ADDR_WIDTH-1:0]   waddr,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [STRB_WIDTH-1:0]   wstrb
);

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ISSUE,
        R_WAIT,
        R_DATA
    } r_state_t;

    // Address of the beat following addr. WRAP keeps the high bits and lets
    // the low bits roll over inside a (len+1)*size window; the reserved
    // burst encoding behaves like INCR.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] incr;
        logic [ADDR_WIDTH-1:0] mask;
        logic [ADDR_WIDTH-1:0] result;
        step = ADDR_WIDTH'(1) << size;
        incr = addr + step;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   result = addr;
            2'b10:   result = (addr & ~mask) | (incr & mask);
            default: result = incr;
        endcase
        return result;
    endfunction

    w_state_t              w_state;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [7:0]            w_cnt;
    logic [ADDR_WIDTH-1:0] w_addr_next;

    r_state_t              r_state;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr_next;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  unused_sideband;

    assign w_addr_next = next_addr(w_addr, w_size, w_len, w_burst);
    assign r_addr_next = next_addr(r_addr, r_size, r_len, r_burst);

    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;
    assign s_axi_buser = '0;
    assign s_axi_ruser = '0;

    // With REG_DATA=0 the register bus must hold rdata until the R handshake.
    assign s_axi_rdata = (REG_DATA != 0) ? rdata_q : rdata;

    assign unused_sideband = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                               s_axi_awqos, s_axi_awregion, s_axi_awuser,
                               s_axi_wlast, s_axi_wuser,
                               s_axi_arlock, s_axi_arcache, s_axi_arprot,
                               s_axi_arqos, s_axi_arregion, s_axi_aruser};

    // ---- write engine: AW capture -> one wr per W beat -> B response ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            w_id          <= '0;
            w_addr        <= '0;
            w_len         <= '0;
            w_size        <= '0;
            w_burst       <= '0;
            w_cnt         <= '0;
            wr            <= 1'b0;
            waddr         <= '0;
            wdata         <= '0;
            wstrb         <= '0;
        end else begin
            wr <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    s_axi_awready <= 1'b1;
                    if (s_axi_awready && s_axi_awvalid) begin
                        s_axi_awready <= 1'b0;
                        s_axi_wready  <= 1'b1;
                        w_id          <= s_axi_awid;
                        w_addr        <= s_axi_awaddr;
                        w_len         <= s_axi_awlen;
                        w_size        <= s_axi_awsize;
                        w_burst       <= s_axi_awburst;
                        w_cnt         <= '0;
                        w_state       <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (s_axi_wready && s_axi_wvalid) begin
                        wr     <= 1'b1;
                        waddr  <= w_addr;
                        wdata  <= s_axi_wdata;
                        wstrb  <= s_axi_wstrb;
                        w_addr <= w_addr_next;
                        w_cnt  <= w_cnt + 8'd1;
                        // Burst length comes from awlen, not wlast.
                        if (w_cnt == w_len) begin
                            s_axi_wready <= 1'b0;
                            s_axi_bvalid <= 1'b1;
                            s_axi_bid    <= w_id;
                            w_state      <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid  <= 1'b0;
                        s_axi_awready <= 1'b1;
                        w_state       <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // ---- read engine: AR capture -> rd -> wait rvalid -> R beat, per beat ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rlast   <= 1'b0;
            r_id          <= '0;
            r_addr        <= '0;
            r_len         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
            r_cnt         <= '0;
            rdata_q       <= '0;
            rd            <= 1'b0;
            raddr         <= '0;
        end else begin
            rd <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    s_axi_arready <= 1'b1;
                    if (s_axi_arready && s_axi_arvalid) begin
                        s_axi_arready <= 1'b0;
                        r_id          <= s_axi_arid;
                        r_addr        <= s_axi_araddr;
                        r_len         <= s_axi_arlen;
                        r_size        <= s_axi_arsize;
                        r_burst       <= s_axi_arburst;
                        r_cnt         <= '0;
                        // Strobe is raised on entry so it lands the cycle
                        // after the AR handshake.
                        rd            <= 1'b1;
                        raddr         <= s_axi_araddr;
                        r_state       <= R_ISSUE;
                    end
                end
                R_ISSUE, R_WAIT: begin
                    // rvalid may already answer in the same cycle as rd.
                    if (rvalid) begin
                        if (REG_DATA != 0) begin
                            rdata_q <= rdata;
                        end
                        s_axi_rvalid <= 1'b1;
                        s_axi_rid    <= r_id;
                        s_axi_rlast  <= (r_cnt == r_len);
                        r_state      <= R_DATA;
                    end else begin
                        r_state      <= R_WAIT;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        s_axi_rlast  <= 1'b0;
                        if (r_cnt == r_len) begin
                            s_axi_arready <= 1'b1;
                            r_state       <= R_IDLE;
                        end else begin
                            r_addr  <= r_addr_next;
                            raddr   <= r_addr_next;
                            rd      <= 1'b1;
                            r_cnt   <= r_cnt + 8'd1;
                            r_state <= R_ISSUE;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_config_rdwr.sv
// ============================================================================
// tb_axi_config_rdwr
//
// Directed bench for axi_config_rdwr. Two instances share every input except
// the register-bus read data: u_dut0 registers rdata (REG_DATA=1) and u_dut1
// passes it through (REG_DATA=0). Inputs change and outputs are sampled on
// the falling edge.
// ============================================================================
module tb_axi_config_rdwr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [7:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [3:0]  wstrb_i = '0;
    logic        wlast_i = 1'b0;
    logic        wvalid = 1'b0;
    logic        bready = 1'b0;
    logic [7:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        rready = 1'b0;
    logic [31:0] rdata0_i = '0;
    logic [31:0] rdata1_i = '0;
    logic        rvalid_i = 1'b0;

    logic        awready0, wready0, bvalid0, arready0, svalid0, rlast0, rd0, wr0;
    logic [7:0]  bid0, rid0;
    logic [1:0]  bresp0, rresp0;
    logic [0:0]  buser0, ruser0;
    logic [31:0] sdata0, raddr0, waddr0, wdata0;
    logic [3:0]  wstrb0;

    logic        awready1, wready1, bvalid1, arready1, svalid1, rlast1, rd1, wr1;
    logic [7:0]  bid1, rid1;
    logic [1:0]  bresp1, rresp1;
    logic [0:0]  buser1, ruser1;
    logic [31:0] sdata1, raddr1, waddr1, wdata1;
    logic [3:0]  wstrb1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_config_rdwr #(.REG_DATA(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'h0), .s_axi_awprot(3'h0), .s_axi_awqos(4'h0),
        .s_axi_awregion(4'h0), .s_axi_awuser(1'b0), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready0),
        .s_axi_wdata(wdata_i), .s_axi_wstrb(wstrb_i), .s_axi_wlast(wlast_i),
        .s_axi_wuser(1'b0), .s_axi_wvalid(wvalid), .s_axi_wready(wready0),
        .s_axi_bid(bid0), .s_axi_bresp(bresp0), .s_axi_buser(buser0),
        .s_axi_bvalid(bvalid0), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arlock(1'b0),
        .s_axi_arcache(4'h0), .s_axi_arprot(3'h0), .s_axi_arqos(4'h0),
        .s_axi_arregion(4'h0), .s_axi_aruser(1'b0), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready0),
        .s_axi_rid(rid0), .s_axi_rdata(sdata0), .s_axi_rresp(rresp0),
        .s_axi_rlast(rlast0), .s_axi_ruser(ruser0), .s_axi_rvalid(svalid0),
        .s_axi_rready(rready),
        .rd(rd0), .raddr(raddr0), .rdata(rdata0_i), .rvalid(rvalid_i),
        .wr(wr0), .waddr(waddr0), .wdata(wdata0), .wstrb(wstrb0)
    );

    axi_config_rdwr #(.REG_DATA(0)) u_dut1 (
        .clk(clk), .rst(rst),
        .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
        .s_axi_awsize(awsize), .s_axi_awburst(awburst), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'h0), .s_axi_awprot(3'h0), .s_axi_awqos(4'h0),
        .s_axi_awregion(4'h0), .s_axi_awuser(1'b0), .s_axi_awvalid(awvalid),
        .s_axi_awready(awready1),
        .s_axi_wdata(wdata_i), .s_axi_wstrb(wstrb_i), .s_axi_wlast(wlast_i),
        .s_axi_wuser(1'b0), .s_axi_wvalid(wvalid), .s_axi_wready(wready1),
        .s_axi_bid(bid1), .s_axi_bresp(bresp1), .s_axi_buser(buser1),
        .s_axi_bvalid(bvalid1), .s_axi_bready(bready),
        .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
        .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arlock(1'b0),
        .s_axi_arcache(4'h0), .s_axi_arprot(3'h0), .s_axi_arqos(4'h0),
        .s_axi_arregion(4'h0), .s_axi_aruser(1'b0), .s_axi_arvalid(arvalid),
        .s_axi_arready(arready1),
        .s_axi_rid(rid1), .s_axi_rdata(sdata1), .s_axi_rresp(rresp1),
        .s_axi_rlast(rlast1), .s_axi_ruser(ruser1), .s_axi_rvalid(svalid1),
        .s_axi_rready(rready),
        .rd(rd1), .raddr(raddr1), .rdata(rdata1_i), .rvalid(rvalid_i),
        .wr(wr1), .waddr(waddr1), .wdata(wdata1), .wstrb(wstrb1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, awready0, 0);
        chk({tag, "_wready"},  wready0,  0);
        chk({tag, "_bvalid"},  bvalid0,  0);
        chk({tag, "_bid"},     bid0,     0);
        chk({tag, "_bresp"},   bresp0,   0);
        chk({tag, "_arready"}, arready0, 0);
        chk({tag, "_rvalid"},  svalid0,  0);
        chk({tag, "_rid"},     rid0,     0);
        chk({tag, "_rresp"},   rresp0,   0);
        chk({tag, "_rlast"},   rlast0,   0);
        chk({tag, "_rdata"},   sdata0,   0);
        chk({tag, "_rd"},      rd0,      0);
        chk({tag, "_raddr"},   raddr0,   0);
        chk({tag, "_wr"},      wr0,      0);
        chk({tag, "_waddr"},   waddr0,   0);
        chk({tag, "_wdata"},   wdata0,   0);
        chk({tag, "_wstrb"},   wstrb0,   0);
    endtask

    task automatic aw_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        chk("awready_idle", awready0, 1);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
        awvalid = 1'b1;
        tick;
        awvalid = 1'b0;
        chk("awready_busy", awready0, 0);
        chk("wready_open", wready0, 1);
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb,
                          input logic [31:0] exp_addr, input int gap);
        chk("wready_beat", wready0, 1);
        wdata_i = data; wstrb_i = strb; wvalid = 1'b1;
        tick;
        wvalid = 1'b0;
        chk("wr_pulse", wr0, 1);
        chk("waddr", waddr0, exp_addr);
        chk("wdata", wdata0, data);
        chk("wstrb", wstrb0, strb);
        for (int g = 0; g < gap; g++) begin
            tick;
            chk("wr_gap_idle", wr0, 0);
        end
    endtask

    task automatic b_resp(input logic [7:0] exp_id, input int stall);
        chk("bvalid_set", bvalid0, 1);
        chk("bid", bid0, exp_id);
        chk("bresp", bresp0, 0);
        chk("wready_closed", wready0, 0);
        for (int s = 0; s < stall; s++) begin
            tick;
            chk("bvalid_hold", bvalid0, 1);
            chk("bid_hold", bid0, exp_id);
            chk("wr_after_last", wr0, 0);
        end
        bready = 1'b1;
        tick;
        bready = 1'b0;
        chk("bvalid_clear", bvalid0, 0);
        chk("awready_return", awready0, 1);
        chk("wr_after_b", wr0, 0);
    endtask

    task automatic ar_send(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        chk("arready_idle", arready0, 1);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1'b1;
        tick;
        arvalid = 1'b0;
        chk("arready_busy", arready0, 0);
    endtask

    // One read beat: wait (bounded) for rd, answer after dly cycles (0 = same
    // cycle as rd) with data equal to the address, hold R for stall cycles,
    // then handshake.
    task automatic r_beat(input logic [31:0] exp_addr, input logic exp_last, input logic [7:0] exp_id,
                          input int dly, input int stall);
        int n;
        n = 0;
        while (rd0 !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        chk("rd_pulse", rd0, 1);
        chk("raddr", raddr0, exp_addr);
        chk("rd_pulse_inst1", rd1, 1);
        if (dly > 0) begin
            tick;
            chk("rd_one_cycle", rd0, 0);
            for (int d = 1; d < dly; d++) tick;
        end
        rdata0_i = exp_addr; rdata1_i = exp_addr; rvalid_i = 1'b1;
        tick;
        rvalid_i = 1'b0;
        rdata0_i = 32'hBAD0_BAD0;
        chk("rvalid_set", svalid0, 1);
        chk("rdata_reg", sdata0, exp_addr);
        chk("rdata_pass", sdata1, exp_addr);
        chk("rlast", rlast0, exp_last);
        chk("rid", rid0, exp_id);
        chk("rresp", rresp0, 0);
        chk("rd_quiet", rd0, 0);
        for (int s = 0; s < stall; s++) begin
            tick;
            chk("rvalid_hold", svalid0, 1);
            chk("rdata_hold", sdata0, exp_addr);
            chk("rdata_pass_hold", sdata1, exp_addr);
            chk("rlast_hold", rlast0, exp_last);
            chk("rd_stalled", rd0, 0);
        end
        rready = 1'b1;
        tick;
        rready = 1'b0;
        chk("rvalid_clear", svalid0, 0);
        if (exp_last) chk("arready_return", arready0, 1);
        else          chk("rd_next", rd0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1 rst = 1'b0;
        tick;
        chk_reset_outputs("reset");
        rst = 1'b1;
        tick;
        chk("awready_after_reset", awready0, 1);
        chk("arready_after_reset", arready0, 1);

        // Single write
        aw_send(8'h3C, 32'h10, 8'd0, 3'd2, 2'b01);
        w_beat(32'hDEAD_BEEF, 4'hF, 32'h10, 0);
        b_resp(8'h3C, 0);

        // INCR write burst with W gaps, B held two cycles
        aw_send(8'h42, 32'h100, 8'd3, 3'd2, 2'b01);
        w_beat(32'h1111_0000, 4'hF, 32'h100, 2);
        w_beat(32'h2222_0001, 4'h3, 32'h104, 0);
        w_beat(32'h3333_0002, 4'hC, 32'h108, 1);
        w_beat(32'h4444_0003, 4'h1, 32'h10C, 0);
        b_resp(8'h42, 2);

        // WRAP write: 0x38 0x3C 0x30 0x34
        aw_send(8'h07, 32'h38, 8'd3, 3'd2, 2'b10);
        w_beat(32'hA0, 4'hF, 32'h38, 0);
        w_beat(32'hA1, 4'hF, 32'h3C, 0);
        w_beat(32'hA2, 4'hF, 32'h30, 0);
        w_beat(32'hA3, 4'hF, 32'h34, 0);
        b_resp(8'h07, 0);

        // FIXED write: 0x40 three times
        aw_send(8'h08, 32'h40, 8'd2, 3'd2, 2'b00);
        w_beat(32'hB0, 4'hF, 32'h40, 0);
        w_beat(32'hB1, 4'hF, 32'h40, 0);
        w_beat(32'hB2, 4'hF, 32'h40, 0);
        b_resp(8'h08, 0);

        // Reserved burst type behaves as INCR
        aw_send(8'h09, 32'h200, 8'd1, 3'd2, 2'b11);
        w_beat(32'hC0, 4'hF, 32'h200, 0);
        w_beat(32'hC1, 4'hF, 32'h204, 0);
        b_resp(8'h09, 0);

        // INCR read burst, back-pressure on beat 1, same-cycle rvalid on beat 2
        ar_send(8'h5A, 32'h20, 8'd3, 3'd2, 2'b01);
        r_beat(32'h20, 1'b0, 8'h5A, 2, 0);
        r_beat(32'h24, 1'b0, 8'h5A, 2, 5);
        r_beat(32'h28, 1'b0, 8'h5A, 0, 0);
        r_beat(32'h2C, 1'b1, 8'h5A, 2, 0);

        // WRAP read
        ar_send(8'h61, 32'h38, 8'd3, 3'd2, 2'b10);
        r_beat(32'h38, 1'b0, 8'h61, 2, 0);
        r_beat(32'h3C, 1'b0, 8'h61, 2, 0);
        r_beat(32'h30, 1'b0, 8'h61, 2, 0);
        r_beat(32'h34, 1'b1, 8'h61, 2, 0);

        // FIXED read
        ar_send(8'h62, 32'h40, 8'd2, 3'd2, 2'b00);
        r_beat(32'h40, 1'b0, 8'h62, 2, 0);
        r_beat(32'h40, 1'b0, 8'h62, 1, 0);
        r_beat(32'h40, 1'b1, 8'h62, 2, 0);

        // Reset mid-burst: write beat 2 pending, read beat 1 being issued
        aw_send(8'h11, 32'h300, 8'd3, 3'd2, 2'b01);
        w_beat(32'hD0, 4'hF, 32'h300, 0);
        w_beat(32'hD1, 4'hF, 32'h304, 0);
        ar_send(8'h22, 32'h400, 8'd3, 3'd2, 2'b01);
        r_beat(32'h400, 1'b0, 8'h22, 2, 0);
        chk("rd_before_reset", rd0, 1);
        wdata_i = 32'hD2; wvalid = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        wvalid = 1'b0;
        tick;
        tick;
        chk("bvalid_dropped", bvalid0, 0);
        chk("rvalid_dropped", svalid0, 0);
        chk("awready_in_reset", awready0, 0);
        rst = 1'b1;
        tick;
        chk("awready_after_release", awready0, 1);
        chk("arready_after_release", arready0, 1);
        chk("bvalid_after_release", bvalid0, 0);

        // Fresh transfers after reset
        aw_send(8'h33, 32'h500, 8'd0, 3'd2, 2'b01);
        w_beat(32'hCAFE_F00D, 4'h5, 32'h500, 0);
        b_resp(8'h33, 0);
        ar_send(8'h44, 32'h600, 8'd0, 3'd2, 2'b01);
        r_beat(32'h600, 1'b1, 8'h44, 2, 0);

        tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
